picosoc_uart_dbg_bridge: RTL
============================

// Module: picosoc_uart_dbg_bridge
// PURPOSE
//  UART-driven debug initiator on the picosoc iomem bus, the master counterpart to iomem responders such as the UART peripheral.
//  A host on the serial link sends framed read/write commands. The bridge decodes them, runs one iomem transaction per frame and returns status/data over serial.
//  Gives the host peek/poke access to peripherals without CPU involvement.
// PARAMETERS
//  CLOCK_SPEED_HZ  50_000_000  clk frequency
//  BAUD_RATE       115200      serial rate; DIV = CLOCK_SPEED_HZ/BAUD_RATE, must be >= 4
//  TIMEOUT_CYCLES  1024        bus watchdog limit (only with PICOSOC_DBG_BRIDGE_TIMEOUT_EN)
// PORTS
//  clk          in   1   system clock
//  resetn       in   1   asynchronous, active-low reset
//  uart_rx_i    in   1   serial in, idle high, 8N1
//  uart_tx_o    out  1   serial out, idle high, 8N1
//  iomem_valid  out  1   transaction request
//  iomem_wstrb  out  4   byte strobes; 0 = read
//  iomem_addr   out  32  address
//  iomem_wdata  out  32  write data
//  iomem_rdata  in   32  read data, valid when iomem_ready=1
//  iomem_ready  in   1   responder completion
//  busy_o       out  1   high from command byte accepted until last response byte sent
// BEHAVIOUR
//  Reset: all outputs 0 except uart_tx_o=1; FSM IDLE; RX/TX idle. Takes effect immediately, aborting any bus or serial activity.
//  RX:
//   - uart_rx_i passes through a 2-flop synchroniser.
//   - Falling edge starts a frame; start bit is re-checked at DIV/2. If high, it is a false start and the frame is dropped.
//   - 8 data bits (LSB first) are sampled every DIV cycles. Stop bit is sampled; if low, framing error and the byte is discarded.
//   - Produces a 1-cycle byte strobe at mid-stop-bit.
//  TX:
//   - 10-bit shift (start, 8 data LSB first, stop), DIV cycles per bit.
//   - Accepts a byte only when idle.
//  Frame format, multi-byte fields MSB first:
//   - 0x57 'W' + A3..A0 + D3..D0 -> write, wstrb=4'hF, reply 0x4B 'K'
//   - 0x52 'R' + A3..A0 -> read, reply D3..D0 (iomem_rdata captured on ready)
//   - Any other byte in IDLE is ignored.
//  FSM: IDLE -> ADDR (4 bytes) -> [W: DATA (4 bytes)] -> BUS -> RESP -> IDLE.
//  BUS:
//   - iomem_valid=1 with addr/wdata/wstrb held stable until iomem_ready=1 is sampled.
//   - iomem_valid drops the next cycle; wstrb returns to 0.
//   - Minimum latency is 1 cycle with an immediately-ready responder.
//   - Ready sampled in the same cycle valid rises completes the transaction.
//  RESP: TX bytes are queued back-to-back. RESP -> IDLE after the final stop bit completes.
//  Received bytes during BUS/RESP are dropped; the parser resumes only in IDLE.
//  No inter-byte timeout; a partial frame waits indefinitely for its remaining bytes.
//  iomem_ready while iomem_valid=0 is ignored.
// CONFIGURATION
//  PICOSOC_DBG_BRIDGE_TIMEOUT_EN defined:
//   - BUS counts cycles; on reaching TIMEOUT_CYCLES without ready, drops valid and replies a single 0x45 'E' for both R and W.
//   - Ready arriving in the same cycle as expiry wins (normal reply).
//  Undefined: BUS waits for ready forever; no counter logic is synthesised.
// TESTING
//  (sim: CLOCK_SPEED_HZ=1_000_000, BAUD_RATE=100_000, DIV=10)
//  1. Send 57 02 00 00 04 00 00 00 1B -> one iomem write addr=0x0200_0004, wdata=0x1B, wstrb=F; valid held 3 cycles until ready; TX 0x4B.
//  2. Send 52 10 00 00 00, responder rdata=0xDEADBEEF ready after 0 cycles -> valid exactly 1 cycle; TX DE AD BE EF.
//  3. Glitch rx low 3 cycles, then byte with stop bit low, then 0x41 -> no bus activity, no TX, busy_o stays 0.
//  4. Send extra 0x52 during RESP of test 2 -> ignored; only 4 response bytes; FSM back in IDLE.
//  5. Assert resetn=0 mid-BUS -> iomem_valid=0, uart_tx_o=1 immediately; after release, test 1 passes again.
//  6. TIMEOUT_EN, TIMEOUT_CYCLES=16, ready never -> valid drops after 16 cycles, TX 0x45; without macro valid stays high.

Source files
------------

// File: rtl/picosoc_uart_dbg_bridge.sv
// picosoc_uart_dbg_bridge
//   UART-driven debug master for the picosoc iomem bus. A host sends framed
//   commands over 8N1 serial:
//     'W'(0x57) A3 A2 A1 A0 D3 D2 D1 D0 -> iomem write (wstrb=F), reply 'K'
//     'R'(0x52) A3 A2 A1 A0             -> iomem read, reply D3 D2 D1 D0
//   Multi-byte fields are MSB first. Other bytes received while idle are ignored.
//
// Parameters
//   CLOCK_SPEED_HZ  clk frequency
//   BAUD_RATE       serial rate, DIV = CLOCK_SPEED_HZ/BAUD_RATE (>= 4)
//   TIMEOUT_CYCLES  bus watchdog limit
//
// Optional feature: define PICOSOC_DBG_BRIDGE_TIMEOUT_EN to add a bus watchdog
//   that abandons a transaction after TIMEOUT_CYCLES and replies 'E'(0x45).
//
// Ports
//   clk, resetn        clock, asynchronous active-low reset
//   uart_rx_i          serial in (idle high)
//   uart_tx_o          serial out (idle high)
//   iomem_valid/wstrb/addr/wdata   master request (wstrb=0 for reads)
//   iomem_rdata/ready  responder completion and read data
//   busy_o             high from command byte accepted until reply sent
module picosoc_uart_dbg_bridge #(
   parameter int CLOCK_SPEED_HZ = 50_000_000,
   parameter int BAUD_RATE      = 115200,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        uart_rx_i,
   output logic        uart_tx_o,
   output logic        iomem_valid,
   output logic [3:0]  iomem_wstrb,
   output logic [31:0] iomem_addr,
   output logic [31:0] iomem_wdata,
   input  logic [31:0] iomem_rdata,
   input  logic        iomem_ready,
   output logic        busy_o
);

   localparam int          DIV       = CLOCK_SPEED_HZ / BAUD_RATE;
   localparam logic [15:0] DIV_LAST  = 16'(DIV - 1);
   localparam logic [15:0] HALF_LAST = 16'(DIV / 2 - 1);

   if (DIV < 4) begin : g_div_chk
      $error("CLOCK_SPEED_HZ/BAUD_RATE must be at least 4");
   end
   if (TIMEOUT_CYCLES < 1) begin : g_to_chk
      $error("TIMEOUT_CYCLES must be at least 1");
   end

   // ---------------- receiver ----------------
   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

   rx_state_t   rx_state;
   logic        rx_meta, rx_s, rx_prev;
   logic [15:0] rx_cnt;
   logic [2:0]  rx_bit;
   logic [7:0]  rx_sh;
   logic        rx_strobe;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rx_meta   <= 1'b1;
         rx_s      <= 1'b1;
         rx_prev   <= 1'b1;
         rx_state  <= RX_IDLE;
         rx_cnt    <= '0;
         rx_bit    <= '0;
         rx_sh     <= '0;
         rx_strobe <= 1'b0;
      end else begin
         rx_meta   <= uart_rx_i;
         rx_s      <= rx_meta;
         rx_prev   <= rx_s;
         rx_strobe <= 1'b0;
         case (rx_state)
            RX_IDLE: begin
               if (rx_prev && !rx_s) begin
                  rx_state <= RX_START;
                  rx_cnt   <= '0;
               end
            end
            RX_START: begin
               // Half a bit later the line must still be low, otherwise it was a glitch.
               if (rx_cnt == HALF_LAST) begin
                  rx_cnt   <= '0;
                  rx_bit   <= '0;
                  rx_state <= rx_s ? RX_IDLE : RX_DATA;
               end else begin
                  rx_cnt <= rx_cnt + 16'd1;
               end
            end
            RX_DATA: begin
               if (rx_cnt == DIV_LAST) begin
                  rx_cnt <= '0;
                  rx_sh  <= {rx_s, rx_sh[7:1]};
                  if (rx_bit == 3'd7) rx_state <= RX_STOP;
                  rx_bit <= rx_bit + 3'd1;
               end else begin
                  rx_cnt <= rx_cnt + 16'd1;
               end
            end
            RX_STOP: begin
               // A low stop bit is a framing error: the byte is silently dropped.
               if (rx_cnt == DIV_LAST) begin
                  rx_cnt    <= '0;
                  rx_strobe <= rx_s;
                  rx_state  <= RX_IDLE;
               end else begin
                  rx_cnt <= rx_cnt + 16'd1;
               end
            end
            default: rx_state <= RX_IDLE;
         endcase
      end
   end

   // ---------------- transmitter ----------------
   logic        tx_start;
   logic [7:0]  tx_data;
   logic        tx_busy;
   logic [15:0] tx_cnt;
   logic [3:0]  tx_bits;
   logic [8:0]  tx_sh;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         uart_tx_o <= 1'b1;
         tx_busy   <= 1'b0;
         tx_cnt    <= '0;
         tx_bits   <= '0;
         tx_sh     <= '1;
      end else if (!tx_busy) begin
         if (tx_start) begin
            uart_tx_o <= 1'b0;
            tx_sh     <= {1'b1, tx_data};
            tx_busy   <= 1'b1;
            tx_cnt    <= '0;
            tx_bits   <= '0;
         end
      end else if (tx_cnt == DIV_LAST) begin
         tx_cnt <= '0;
         // Nine shifts put out d0..d7 and the stop bit; the tenth boundary ends the frame.
         if (tx_bits == 4'd9) begin
            tx_busy <= 1'b0;
         end else begin
            uart_tx_o <= tx_sh[0];
            tx_sh     <= {1'b1, tx_sh[8:1]};
            tx_bits   <= tx_bits + 4'd1;
         end
      end else begin
         tx_cnt <= tx_cnt + 16'd1;
      end
   end

   // ---------------- command FSM ----------------
   typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_BUS, S_RESP} state_t;

   state_t      state;
   logic        is_write;
   logic [1:0]  byte_cnt;
   logic [31:0] resp_sh;
   logic [2:0]  resp_left;
`ifdef PICOSOC_DBG_BRIDGE_TIMEOUT_EN
   localparam int             TO_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
   logic [TO_W-1:0] to_cnt;
`endif

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state       <= S_IDLE;
         is_write    <= 1'b0;
         byte_cnt    <= '0;
         resp_sh     <= '0;
         resp_left   <= '0;
         tx_start    <= 1'b0;
         tx_data     <= '0;
         iomem_valid <= 1'b0;
         iomem_wstrb <= '0;
         iomem_addr  <= '0;
         iomem_wdata <= '0;
         busy_o      <= 1'b0;
`ifdef PICOSOC_DBG_BRIDGE_TIMEOUT_EN
         to_cnt      <= '0;
`endif
      end else begin
         tx_start <= 1'b0;
         case (state)
            S_IDLE: begin
`ifdef PICOSOC_DBG_BRIDGE_TIMEOUT_EN
               to_cnt <= '0;
`endif
               if (rx_strobe && (rx_sh == 8'h57 || rx_sh == 8'h52)) begin
                  is_write <= (rx_sh == 8'h57);
                  byte_cnt <= '0;
                  busy_o   <= 1'b1;
                  state    <= S_ADDR;
               end
            end
            S_ADDR: begin
               if (rx_strobe) begin
                  iomem_addr <= {iomem_addr[23:0], rx_sh};
                  byte_cnt   <= byte_cnt + 2'd1;
                  if (byte_cnt == 2'd3) begin
                     if (is_write) begin
                        state <= S_DATA;
                     end else begin
                        iomem_valid <= 1'b1;
                        iomem_wstrb <= 4'h0;
                        state       <= S_BUS;
                     end
                  end
               end
            end
            S_DATA: begin
               if (rx_strobe) begin
                  iomem_wdata <= {iomem_wdata[23:0], rx_sh};
                  byte_cnt    <= byte_cnt + 2'd1;
                  if (byte_cnt == 2'd3) begin
                     iomem_valid <= 1'b1;
                     iomem_wstrb <= 4'hF;
                     state       <= S_BUS;
                  end
               end
            end
            S_BUS: begin
               // Ready takes priority over a watchdog expiry in the same cycle.
               if (iomem_valid && iomem_ready) begin
                  iomem_valid <= 1'b0;
                  iomem_wstrb <= 4'h0;
                  resp_sh     <= is_write ? {8'h4B, 24'h0} : iomem_rdata;
                  resp_left   <= is_write ? 3'd1 : 3'd4;
                  state       <= S_RESP;
               end
`ifdef PICOSOC_DBG_BRIDGE_TIMEOUT_EN
               else if (to_cnt == TO_LAST) begin
                  iomem_valid <= 1'b0;
                  iomem_wstrb <= 4'h0;
                  resp_sh     <= {8'h45, 24'h0};
                  resp_left   <= 3'd1;
                  state       <= S_RESP;
               end else begin
                  to_cnt <= to_cnt + 1'b1;
               end
`endif
            end
            S_RESP: begin
               // tx_busy lags tx_start by a cycle, so both must be clear before the next byte.
               if (!tx_busy && !tx_start) begin
                  if (resp_left != 3'd0) begin
                     tx_start  <= 1'b1;
                     tx_data   <= resp_sh[31:24];
                     resp_sh   <= {resp_sh[23:0], 8'h00};
                     resp_left <= resp_left - 3'd1;
                  end else begin
                     busy_o <= 1'b0;
                     state  <= S_IDLE;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
